// File: rtl/hyperbus_arbiter.sv
// rtl/hyperbus_arbiter.sv - round-robin arbiter sharing one Hyperbus controller port
module hyperbus_arbiter #(
    parameter int NPORTS          = 2,
    parameter int IDX_W           = 3,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16
) (
    input  logic                                hbus_clk,
    input  logic                                hbus_rst,
    input  logic [NPORTS*HBUS_ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [NPORTS*HBUS_DATA_WIDTH-1:0]   m_dat_i,
    input  logic [NPORTS-1:0]                   m_rrq,
    input  logic [NPORTS-1:0]                   m_wrq,
    output logic [HBUS_DATA_WIDTH-1:0]          m_dat_o,
    output logic [NPORTS-1:0]                   m_ready,
    output logic [NPORTS-1:0]                   m_valid,
    output logic [NPORTS-1:0]                   m_busy,
    output logic [HBUS_ADDR_WIDTH-1:0]          hbus_adr_o,
    output logic [HBUS_DATA_WIDTH-1:0]          hbus_dat_o,
    input  logic [HBUS_DATA_WIDTH-1:0]          hbus_dat_i,
    output logic                                hbus_rrq,
    output logic                                hbus_wrq,
    input  logic                                hbus_ready,
    input  logic                                hbus_valid,
    input  logic                                hbus_busy,
    output logic                                grant_valid,
    output logic [IDX_W-1:0]                    grant_idx,
    output logic                                err_both
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   grant_idx_q;
    logic [IDX_W-1:0]   grant_idx_d;
    logic               grant_valid_q;
    logic               err_both_q;
    logic               live_q;
    logic               pick_found;
    logic [NPORTS-1:0]  req_any;

    logic                       sel_rrq;
    logic                       sel_wrq;
    logic [HBUS_ADDR_WIDTH-1:0] sel_adr;
    logic [HBUS_DATA_WIDTH-1:0] sel_dat;

    assign req_any = m_rrq | m_wrq;

    // Round-robin pick: first requester after the previous owner, wrapping
    always_comb begin
        int cand;
        pick_found  = 1'b0;
        grant_idx_d = '0;
        cand        = 0;
        for (int i = 1; i <= NPORTS; i++) begin
            cand = (int'(last_q) + i) % NPORTS;
            if (!pick_found && req_any[cand]) begin
                pick_found  = 1'b1;
                grant_idx_d = IDX_W'(cand);
            end
        end
    end

    // Select the owning port's request, address and write data
    always_comb begin
        sel_rrq = 1'b0;
        sel_wrq = 1'b0;
        sel_adr = '0;
        sel_dat = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (grant_idx_q == IDX_W'(k)) begin
                sel_rrq = m_rrq[k];
                sel_wrq = m_wrq[k];
                sel_adr = m_adr_i[k*HBUS_ADDR_WIDTH +: HBUS_ADDR_WIDTH];
                sel_dat = m_dat_i[k*HBUS_DATA_WIDTH +: HBUS_DATA_WIDTH];
            end
        end
    end

    // Controller-side drive: pass-through only while granted; read wins a rrq+wrq clash
    always_comb begin
        hbus_rrq   = 1'b0;
        hbus_wrq   = 1'b0;
        hbus_adr_o = '0;
        hbus_dat_o = '0;
        if (state_q == S_GRANT) begin
            hbus_rrq   = sel_rrq;
            hbus_wrq   = sel_wrq & ~sel_rrq;
            hbus_adr_o = sel_adr;
            hbus_dat_o = sel_dat;
        end
    end

    // Requester-side handshake: owner sees the controller, everyone else sees busy
    always_comb begin
        m_ready = '0;
        m_valid = '0;
        m_busy  = '1;
        for (int k = 0; k < NPORTS; k++) begin
            if (!live_q) begin
                m_busy[k] = 1'b1;
            end else if (state_q == S_IDLE) begin
                m_busy[k] = hbus_busy;
            end else if (grant_idx_q == IDX_W'(k)) begin
                m_busy[k]  = hbus_busy;
                m_ready[k] = (state_q == S_GRANT) && hbus_ready;
                m_valid[k] = (state_q == S_GRANT) && hbus_valid;
            end
        end
    end

    assign m_dat_o     = hbus_dat_i;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign err_both    = err_both_q;

    // Grant state machine; live_q keeps busy asserted until the first edge out of reset
    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state_q       <= S_IDLE;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            last_q        <= IDX_W'(NPORTS - 1);
            err_both_q    <= 1'b0;
            live_q        <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (!hbus_busy && pick_found) begin
                        grant_idx_q   <= grant_idx_d;
                        grant_valid_q <= 1'b1;
                        state_q       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (sel_rrq && sel_wrq) begin
                        err_both_q <= 1'b1;
                    end
                    if (!sel_rrq && !sel_wrq) begin
                        last_q  <= grant_idx_q;
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!hbus_busy) begin
                        grant_valid_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    grant_valid_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// tb/tb_hyperbus_arbiter.sv - directed-vector bench for hyperbus_arbiter
module tb_hyperbus_arbiter;

    localparam int NP = 2;
    localparam int IW = 3;
    localparam int AW = 32;
    localparam int DW = 16;

    logic             hbus_clk = 1'b0;
    logic             hbus_rst = 1'b1;
    logic [NP*AW-1:0] m_adr_i;
    logic [NP*DW-1:0] m_dat_i;
    logic [NP-1:0]    m_rrq;
    logic [NP-1:0]    m_wrq;
    logic [DW-1:0]    m_dat_o;
    logic [NP-1:0]    m_ready;
    logic [NP-1:0]    m_valid;
    logic [NP-1:0]    m_busy;
    logic [AW-1:0]    hbus_adr_o;
    logic [DW-1:0]    hbus_dat_o;
    logic [DW-1:0]    hbus_dat_i;
    logic             hbus_rrq;
    logic             hbus_wrq;
    logic             hbus_ready;
    logic             hbus_valid;
    logic             hbus_busy;
    logic             grant_valid;
    logic [IW-1:0]    grant_idx;
    logic             err_both;

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0] exp_dat [NP];
    logic [AW-1:0] exp_adr [NP];
    int            exp_own [4];

    hyperbus_arbiter #(
        .NPORTS(NP), .IDX_W(IW), .HBUS_ADDR_WIDTH(AW), .HBUS_DATA_WIDTH(DW)
    ) dut (
        .hbus_clk(hbus_clk), .hbus_rst(hbus_rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_rrq(m_rrq), .m_wrq(m_wrq),
        .m_dat_o(m_dat_o), .m_ready(m_ready), .m_valid(m_valid), .m_busy(m_busy),
        .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o), .hbus_dat_i(hbus_dat_i),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_ready(hbus_ready),
        .hbus_valid(hbus_valid), .hbus_busy(hbus_busy),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .err_both(err_both)
    );

    always #5 hbus_clk = ~hbus_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge hbus_clk);
            if (grant_valid && (hbus_rrq || hbus_wrq)) seen = 1'b1;
        end
        chk({tag, "_grant_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        exp_adr[0] = 32'h0000_1000;
        exp_adr[1] = 32'h0000_2100;
        exp_dat[0] = 16'hA000;
        exp_dat[1] = 16'hB001;
        exp_own[0] = 0;
        exp_own[1] = 1;
        exp_own[2] = 0;
        exp_own[3] = 1;
        m_adr_i    = {exp_adr[1], exp_adr[0]};
        m_dat_i    = {exp_dat[1], exp_dat[0]};
        m_rrq      = '0;
        m_wrq      = '0;
        hbus_dat_i = '0;
        hbus_ready = 1'b0;
        hbus_valid = 1'b0;
        hbus_busy  = 1'b0;

        // reset state
        repeat (2) @(negedge hbus_clk);
        chk("rst_grant_valid", 64'(grant_valid), 64'd0);
        chk("rst_hbus_rrq", 64'(hbus_rrq), 64'd0);
        chk("rst_hbus_wrq", 64'(hbus_wrq), 64'd0);
        chk("rst_m_busy", 64'(m_busy), 64'h3);
        chk("rst_err_both", 64'(err_both), 64'd0);
        chk("rst_adr", 64'(hbus_adr_o), 64'd0);
        hbus_rst = 1'b0;
        repeat (2) @(negedge hbus_clk);
        chk("post_rst_m_busy", 64'(m_busy), 64'h0);

        // port 0 read, one-cycle grant latency
        m_rrq = 2'b01;
        @(negedge hbus_clk);
        chk("rd0_grant_valid", 64'(grant_valid), 64'd1);
        chk("rd0_grant_idx", 64'(grant_idx), 64'd0);
        chk("rd0_hbus_rrq", 64'(hbus_rrq), 64'd1);
        chk("rd0_hbus_wrq", 64'(hbus_wrq), 64'd0);
        chk("rd0_adr", 64'(hbus_adr_o), 64'h1000);
        chk("rd0_m_busy", 64'(m_busy), 64'h2);
        hbus_valid = 1'b1;
        hbus_dat_i = 16'hBEEF;
        #1;
        chk("rd0_m_valid", 64'(m_valid), 64'h1);
        chk("rd0_m_dat_o", 64'(m_dat_o), 64'hBEEF);
        hbus_valid = 1'b0;
        m_rrq = 2'b00;
        @(negedge hbus_clk);
        chk("rd0_rel_rrq", 64'(hbus_rrq), 64'd0);
        chk("rd0_rel_gv", 64'(grant_valid), 64'd1);
        @(negedge hbus_clk);
        chk("rd0_idle_gv", 64'(grant_valid), 64'd0);
        chk("rd0_idx_hold", 64'(grant_idx), 64'd0);

        // port 1 asserts both rrq and wrq
        m_rrq = 2'b10;
        m_wrq = 2'b10;
        wait_grant("both");
        chk("both_idx", 64'(grant_idx), 64'd1);
        chk("both_rrq", 64'(hbus_rrq), 64'd1);
        chk("both_wrq", 64'(hbus_wrq), 64'd0);
        @(negedge hbus_clk);
        chk("both_err", 64'(err_both), 64'd1);
        m_rrq = 2'b00;
        m_wrq = 2'b00;
        repeat (2) @(negedge hbus_clk);
        chk("both_done_gv", 64'(grant_valid), 64'd0);
        chk("both_err_sticky", 64'(err_both), 64'd1);

        // both ports writing: strict alternation
        m_wrq = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_grant($sformatf("wr%0d", t));
            chk($sformatf("wr%0d_idx", t), 64'(grant_idx), 64'(exp_own[t]));
            chk($sformatf("wr%0d_wrq", t), 64'(hbus_wrq), 64'd1);
            chk($sformatf("wr%0d_dat", t), 64'(hbus_dat_o), 64'(exp_dat[exp_own[t]]));
            chk($sformatf("wr%0d_adr", t), 64'(hbus_adr_o), 64'(exp_adr[exp_own[t]]));
            hbus_ready = 1'b1;
            #1;
            chk($sformatf("wr%0d_ready", t), 64'(m_ready), 64'(2'b01 << exp_own[t]));
            hbus_ready = 1'b0;
            m_wrq[exp_own[t]] = 1'b0;
            @(negedge hbus_clk);
            chk($sformatf("wr%0d_rel_wrq", t), 64'(hbus_wrq), 64'd0);
            m_wrq[exp_own[t]] = 1'b1;
        end
        m_wrq = 2'b00;
        repeat (2) @(negedge hbus_clk);
        chk("wr_idle_gv", 64'(grant_valid), 64'd0);

        // release held by controller busy for 5 cycles
        m_rrq = 2'b01;
        wait_grant("hold");
        chk("hold_idx", 64'(grant_idx), 64'd0);
        m_rrq     = 2'b10;
        hbus_busy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge hbus_clk);
            chk($sformatf("hold%0d_gv", c), 64'(grant_valid), 64'd1);
            chk($sformatf("hold%0d_busy", c), 64'(m_busy), 64'h3);
        end
        hbus_busy = 1'b0;
        @(negedge hbus_clk);
        chk("hold_idle_gv", 64'(grant_valid), 64'd0);
        chk("hold_idle_busy", 64'(m_busy), 64'h0);
        @(negedge hbus_clk);
        chk("hold_next_gv", 64'(grant_valid), 64'd1);
        chk("hold_next_idx", 64'(grant_idx), 64'd1);
        chk("hold_next_rrq", 64'(hbus_rrq), 64'd1);

        // asynchronous reset while granted
        hbus_rst = 1'b1;
        #1;
        chk("arst_rrq", 64'(hbus_rrq), 64'd0);
        chk("arst_gv", 64'(grant_valid), 64'd0);
        chk("arst_busy", 64'(m_busy), 64'h3);
        chk("arst_err", 64'(err_both), 64'd0);
        m_rrq = 2'b00;
        @(negedge hbus_clk);
        hbus_rst = 1'b0;
        m_rrq = 2'b11;
        wait_grant("arst_first");
        chk("arst_first_idx", 64'(grant_idx), 64'd0);
        m_rrq = 2'b00;
        repeat (2) @(negedge hbus_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
